// File: rtl/sram_like_arbiter_if.sv
// Bundle of the upstream per-channel sram_like buses and the single downstream sram_like port.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface sram_like_arbiter_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [NCH-1:0]    m_req;
  logic [NCH-1:0]    m_wr;
  logic [2*NCH-1:0]  m_size;
  logic [AW*NCH-1:0] m_addr;
  logic [DW*NCH-1:0] m_wdata;
  logic [DW-1:0]     m_rdata;
  logic [NCH-1:0]    m_addr_ok;
  logic [NCH-1:0]    m_data_ok;

  logic              s_req;
  logic              s_wr;
  logic [1:0]        s_size;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [DW-1:0]     s_rdata;
  logic              s_addr_ok;
  logic              s_data_ok;

  modport slave (
    input  m_req, m_wr, m_size, m_addr, m_wdata, s_rdata, s_addr_ok, s_data_ok,
    output m_rdata, m_addr_ok, m_data_ok, s_req, s_wr, s_size, s_addr, s_wdata
  );

  modport master (
    output m_req, m_wr, m_size, m_addr, m_wdata, s_rdata, s_addr_ok, s_data_ok,
    input  m_rdata, m_addr_ok, m_data_ok, s_req, s_wr, s_size, s_addr, s_wdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// NCH:1 sram_like arbiter with round-robin or fixed-priority grant, address-phase lock,
// and an ID FIFO that routes in-order data_ok back to the issuing channel.
module sram_like_arbiter #(
  parameter int NCH    = 2,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int MAXOUT = 2,
  parameter int PRIO   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  sram_like_arbiter_if.slave           bus,
  output logic [$clog2(MAXOUT+1)-1:0]  outstanding_o,
  output logic                         err_unexp_o
);
  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = (MAXOUT > 1) ? $clog2(MAXOUT) : 1;
  localparam int CW  = $clog2(MAXOUT + 1);

  typedef logic [IDW-1:0] id_t;

  id_t           rr_q, rr_d, lock_id_q, lock_id_d;
  logic          lock_q, lock_d, err_q, err_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] occ_q, occ_d;
  id_t           fifo_q [MAXOUT];

  id_t  grant, scan_id, base_id, head;
  logic found, full, empty, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAXOUT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (occ_q == CW'(MAXOUT));
  assign empty = (occ_q == '0);
  assign head  = fifo_q[rd_q];

  // A held lock wins outright; otherwise scan upward from the base with wrap.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    base_id = (PRIO == 0) ? rr_q : '0;
    grant   = lock_id_q;
    found   = lock_q;
    scan_id = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_id = id_t'((int'(base_id) + k) % NCH);
      if (!found && bus.m_req[scan_id]) begin
        found = 1'b1;
        grant = scan_id;
      end
    end
  end

  // Full blocks issue even when a pop lands in the same cycle: no data_ok -> req comb path.
  always_comb begin
    bus.s_req   = rst_n & bus.m_req[grant] & ~full;
    bus.s_wr    = bus.m_wr[grant];
    bus.s_size  = bus.m_size[2*int'(grant) +: 2];
    bus.s_addr  = bus.m_addr[AW*int'(grant) +: AW];
    bus.s_wdata = bus.m_wdata[DW*int'(grant) +: DW];
    bus.m_rdata = bus.s_rdata;

    push = bus.s_req & bus.s_addr_ok;
    pop  = bus.s_data_ok & ~empty;

    bus.m_addr_ok        = '0;
    bus.m_addr_ok[grant] = push;
    bus.m_data_ok        = '0;
    bus.m_data_ok[head]  = pop;
  end

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    rr_d      = rr_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    occ_d     = occ_q + CW'(push) - CW'(pop);
    err_d     = err_q | (bus.s_data_ok & empty);

    if (push) begin
      lock_d = 1'b0;
      wr_d   = ptr_inc(wr_q);
      if (PRIO == 0) rr_d = id_t'((int'(grant) + 1) % NCH);
    end else if (bus.s_req) begin
      // Pin the grant so the request fields stay stable until addr_ok.
      lock_d    = 1'b1;
      lock_id_d = grant;
    end

    if (pop) rd_d = ptr_inc(rd_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      occ_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      occ_q     <= occ_d;
      err_q     <= err_d;
    end
  end

  // NOTE: FIFO storage is not reset; entries are only read when occupancy says they are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= grant;
  end

  assign outstanding_o = occ_q;
  assign err_unexp_o   = err_q;
endmodule
